// File: rtl/soc_system_v5_ctrl_pkg.sv
// Shared constants for the ctrl_in conditioner: default geometry, debounce
// length and the bit positions of the NMR PCB lines on the ctrl_in port.
package soc_system_v5_ctrl_pkg;

    localparam int CTRL_IN_WIDTH        = 8;
    localparam int CTRL_SYNC_STAGES     = 2;
    // 1000 cycles at 50 MHz = 20 us of quiet before a level is accepted.
    localparam int CTRL_DEBOUNCE_CYCLES = 1000;

    localparam int CTRL_BIT_PCB_READY   = 0;
    localparam int CTRL_BIT_PCB_ACK     = 1;
    localparam int CTRL_BIT_PCB_BUSY    = 2;
    localparam int CTRL_BIT_PCB_ERROR   = 3;
    localparam int CTRL_BIT_PCB_PRESENT = 4;
    localparam int CTRL_BIT_TX_GATE     = 5;
    localparam int CTRL_BIT_RX_BLANK    = 6;
    localparam int CTRL_BIT_PA_FAULT    = 7;

    // Counter width that holds 0..cycles-1, never narrower than one bit.
    function automatic int ctrl_cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/soc_system_v5_ctrl_in_db_bit.sv
// One conditioned line: synchroniser chain, debounce counter, stable level,
// registered rise/fall pulses and a sticky change flag.
module soc_system_v5_ctrl_in_db_bit
    import soc_system_v5_ctrl_pkg::*;
#(
    parameter int   SYNC_STAGES     = CTRL_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = CTRL_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    input  logic clr_sticky,
    output logic stable_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic sticky_chg,
    output logic sticky_nxt
);

    localparam int             CNT_W    = ctrl_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sticky_q, sticky_d;
    logic                   synced;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
        synced   = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
        stable_d = stable_q;
        // Any cycle where synced agrees with stable restarts the count, so a
        // bouncing line must be quiet for the full window before it is taken.
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d   = stable_d & ~stable_q;
        fall_d   = ~stable_d & stable_q;
        // Set beats clear so a change landing on a clear strobe is not lost.
        sticky_d = (sticky_q & ~clr_sticky) | rise_d | fall_d;
    end

    // NOTE: state flops use non-blocking assignments only; all combinational
    // work lives in the always_comb above, which gives every output a default.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign stable_out = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign sticky_chg = sticky_q;
    assign sticky_nxt = sticky_d;

endmodule

// File: rtl/soc_system_v5_ctrl_in_cond.sv
// Input conditioner feeding the ctrl_in PIO: WIDTH independent debounced
// lines plus a registered any-change flag usable as an interrupt source.
module soc_system_v5_ctrl_in_cond
    import soc_system_v5_ctrl_pkg::*;
#(
    parameter int               WIDTH           = CTRL_IN_WIDTH,
    parameter int               SYNC_STAGES     = CTRL_SYNC_STAGES,
    parameter int               DEBOUNCE_CYCLES = CTRL_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] clr_sticky,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] sticky_chg,
    output logic             any_chg
);

    logic [WIDTH-1:0] sticky_nxt;
    logic             any_chg_q, any_chg_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_system_v5_ctrl_in_db_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (RESET_VAL[i])
        ) u_db_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .async_in  (async_in[i]),
            .clr_sticky(clr_sticky[i]),
            .stable_out(stable_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .sticky_chg(sticky_chg[i]),
            .sticky_nxt(sticky_nxt[i])
        );
    end

    // Built from next-state flags so the IRQ rises with sticky_chg, not after.
    always_comb begin
        any_chg_d = |sticky_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            any_chg_q <= 1'b0;
        end else begin
            any_chg_q <= any_chg_d;
        end
    end

    assign any_chg = any_chg_q;

endmodule
